clk_rst_ctrl: RTL and testbench

// - Parametrised clock/reset controller for the SoC top: one system clock in, N_CH clock-enable strobes out.
// - Replaces ripple-divided clocks with single-domain enables.
// - Sequences reset release per channel (CPU, memories, peripherals).
// - Per-channel divisors are runtime-programmable.
// - Supports a soft-reset request that re-runs the release sequence without losing the divisor configuration.

---
 rtl/clk_rst_pkg.sv | 24 ++
 rtl/clk_rst_ctrl_div.sv | 55 +++++
 rtl/clk_rst_ctrl.sv | 145 ++++++++++++++
 tb/tb_clk_rst_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared types and width helpers for the clock/reset controller.
package clk_rst_pkg;

    // Reset sequencing states: all channels held, staggered release, running.
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Depth of the resetn deassertion synchroniser.
    localparam int SYNC_STAGES = 2;

    // Bits needed to index n items; never below 1 so single-channel builds keep a real port.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold values 0..max_val; never below 1.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_rst_ctrl_div.sv
// One clock-enable channel: free-running divider with a pending/active divisor pair.
// The active divisor only changes when the counter wraps, so the ce spacing
// never shows a shortened or stretched period.
module clk_en_div
    import clk_rst_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int DIV_INIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             we,
    input  logic [DIV_W-1:0] wdata,
    output logic             ce
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_INIT);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] pend;
    logic [DIV_W-1:0] load_val;

    // A write landing on the wrap cycle is the last write before the wrap, so it bypasses pend.
    always_comb begin
        load_val = we ? wdata : pend;
        ce       = run && ((act < TWO) || (cnt == (act - ONE)));
    end

    // Counter, pending and active divisor; held at count 0 while the channel is in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            act  <= DIV_RST;
            pend <= DIV_RST;
        end else begin
            if (we) begin
                pend <= wdata;
            end
            if (!run) begin
                cnt <= '0;
                act <= load_val;
            end else if (ce) begin
                cnt <= '0;
                act <= load_val;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/clk_rst_ctrl.sv
// Clock/reset controller: synchronises resetn, sequences per-channel reset
// release (hold, then staggered release, then run) and drives one clock-enable
// divider per channel.
module clk_rst_ctrl
    import clk_rst_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DIV_W    = 16,
    parameter int DIV_INIT = 16,
    parameter int RST_HOLD = 16,
    parameter int STAGGER  = 4,
    localparam int CH_W    = idx_w(N_CH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             soft_rst_req,
    output logic [N_CH-1:0]  ce,
    output logic [N_CH-1:0]  ch_rstn,
    output logic             ready
);

    localparam int HOLD_W = cnt_w(RST_HOLD);
    localparam int STAG_W = cnt_w(STAGGER);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'((STAGGER > 0) ? STAGGER - 1 : 0);
    localparam logic [STAG_W-1:0] STAG_ONE  = STAG_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [N_CH-1:0]   REL_FIRST = N_CH'(1);
    localparam logic [N_CH-1:0]   REL_ALL   = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_n;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [STAG_W-1:0] stag_cnt, stag_nxt;
    logic [N_CH-1:0]   rel, rel_nxt;
    logic [N_CH-1:0]   ch_we;

    // Reset synchroniser: assert immediately, release SYNC_STAGES clocks after resetn rises.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_n = sync_q[SYNC_STAGES-1];

    // Sequencer registers: state, hold/stagger counters and the release vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            stag_cnt <= '0;
            rel      <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            stag_cnt <= stag_nxt;
            rel      <= rel_nxt;
        end
    end

    // Next-state logic; a soft reset request always wins and restarts the hold window.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        stag_nxt  = stag_cnt;
        rel_nxt   = rel;
        case (state)
            ST_HOLD: begin
                rel_nxt = '0;
                if (soft_rst_req) begin
                    hold_nxt = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_RELEASE;
                    hold_nxt  = '0;
                    stag_nxt  = '0;
                    rel_nxt   = (STAGGER == 0) ? REL_ALL : REL_FIRST;
                end else begin
                    hold_nxt = hold_cnt + HOLD_ONE;
                end
            end
            ST_RELEASE: begin
                if (soft_rst_req) begin
                    state_nxt = ST_HOLD;
                    hold_nxt  = '0;
                    rel_nxt   = '0;
                end else if (rel == REL_ALL) begin
                    state_nxt = ST_RUN;
                end else if (stag_cnt == STAG_LAST) begin
                    stag_nxt = '0;
                    rel_nxt  = (rel << 1) | REL_FIRST;
                end else begin
                    stag_nxt = stag_cnt + STAG_ONE;
                end
            end
            ST_RUN: begin
                if (soft_rst_req) begin
                    state_nxt = ST_HOLD;
                    hold_nxt  = '0;
                    rel_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_HOLD;
                hold_nxt  = '0;
                rel_nxt   = '0;
            end
        endcase
    end

    // Per-channel write decode; out-of-range indices match no channel.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_we[i] = cfg_we && (32'(cfg_ch) == 32'(i));
        end
    end

    assign ch_rstn = rel;
    assign ready   = (state == ST_RUN);

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            clk_en_div #(
                .DIV_W    (DIV_W),
                .DIV_INIT (DIV_INIT)
            ) u_div (
                .clk   (clk),
                .rst_n (rst_n),
                .run   (rel[g]),
                .we    (ch_we[g]),
                .wdata (cfg_div),
                .ce    (ce[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Bench for clk_rst_ctrl: power-up vector table, hand-written corner sequences
// and a randomized run, all compared against an event-time reference model.
`timescale 1ns/1ps
module tb_clk_rst_ctrl;

    localparam int N  = 4;
    localparam int RH = 16;
    localparam int SG = 4;
    localparam int DI = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [DW-1:0] cfg_div = '0;
    logic          soft_rst_req = 1'b0;
    logic [3:0]    ce, ch_rstn;
    logic          ready;
    logic [2:0]    ce3, ch_rstn3;
    logic          ready3;

    always #5 clk = ~clk;

    clk_rst_ctrl #(.N_CH(4), .DIV_W(DW), .DIV_INIT(DI), .RST_HOLD(RH), .STAGGER(SG)) dut (
        .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .soft_rst_req(soft_rst_req), .ce(ce), .ch_rstn(ch_rstn), .ready(ready)
    );

    // Three-channel copy: cfg_ch=3 is out of range for it and must be ignored.
    clk_rst_ctrl #(.N_CH(3), .DIV_W(DW), .DIV_INIT(DI), .RST_HOLD(RH), .STAGGER(SG)) dut3 (
        .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .soft_rst_req(soft_rst_req), .ce(ce3), .ch_rstn(ch_rstn3), .ready(ready3)
    );

    // Reference model: release times derive from the edge the hold window started on;
    // each channel tracks the edge index of its next ce pulse.
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hold_start = 0;
    int sync_cnt = 0;
    bit up = 1'b0;
    int pend[N];
    int act[N];
    int next_ce[N];

    function automatic bit rel_at(input int x, input int i, input int hs, input bit u);
        return u && (x >= hs + RH + i * SG);
    endfunction

    function automatic int dmax(input int d);
        return (d < 2) ? 1 : d;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        up = 1'b0;
        sync_cnt = 0;
        hold_start = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = DI;
            act[i] = DI;
            next_ce[i] = 0;
        end
    endtask

    task automatic model_edge(input int x);
        bit pre_up;
        bit pre_rel[N];
        pre_up = up;
        for (int i = 0; i < N; i++) pre_rel[i] = rel_at(x - 1, i, hold_start, up);
        if (resetn) begin
            if (!up) begin
                sync_cnt++;
                if (sync_cnt == 2) begin
                    up = 1'b1;
                    hold_start = x;
                end
            end else if (soft_rst_req) begin
                hold_start = x;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (pre_up && cfg_we && (int'(cfg_ch) == i)) pend[i] = int'(cfg_div);
            if (!pre_rel[i]) begin
                act[i] = pend[i];
            end else if (x - 1 == next_ce[i]) begin
                act[i] = pend[i];
                next_ce[i] = x - 1 + dmax(act[i]);
            end
            if (rel_at(x, i, hold_start, up) && !pre_rel[i]) next_ce[i] = x + dmax(act[i]) - 1;
        end
    endtask

    task automatic compare();
        logic [3:0] e_rst, e_ce;
        logic e_rdy, e_rdy3;
        for (int i = 0; i < N; i++) begin
            e_rst[i] = rel_at(cyc, i, hold_start, up);
            e_ce[i]  = e_rst[i] && (cyc == next_ce[i]);
        end
        e_rdy  = up && (cyc >= hold_start + RH + (N - 1) * SG + 1);
        e_rdy3 = up && (cyc >= hold_start + RH + 2 * SG + 1);
        chk("ch_rstn", 32'(ch_rstn), 32'(e_rst));
        chk("ce", 32'(ce), 32'(e_ce));
        chk("ready", 32'(ready), 32'(e_rdy));
        chk("ch_rstn3", 32'(ch_rstn3), 32'(e_rst[2:0]));
        chk("ce3", 32'(ce3), 32'(e_ce[2:0]));
        chk("ready3", 32'(ready3), 32'(e_rdy3));
    endtask

    // One clock: update the model at the posedge, compare at the following negedge.
    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(cyc);
        @(negedge clk);
        compare();
    endtask

    task automatic assert_reset();
        resetn = 1'b0;
        model_reset();
        #1;
        compare();
        chk("rst_async", 32'({ready, ch_rstn, ce, ready3, ch_rstn3, ce3}), 32'd0);
    endtask

    typedef struct {
        int         edge_n;
        logic [3:0] rstn;
        logic       rdy;
        logic [3:0] cev;
    } pu_vec_t;

    pu_vec_t pu[15];

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, ts2, t1;
        pu[0]  = '{2,  4'b0000, 1'b0, 4'b0000};
        pu[1]  = '{17, 4'b0000, 1'b0, 4'b0000};
        pu[2]  = '{18, 4'b0001, 1'b0, 4'b0000};
        pu[3]  = '{21, 4'b0001, 1'b0, 4'b0000};
        pu[4]  = '{22, 4'b0011, 1'b0, 4'b0000};
        pu[5]  = '{26, 4'b0111, 1'b0, 4'b0000};
        pu[6]  = '{30, 4'b1111, 1'b0, 4'b0000};
        pu[7]  = '{31, 4'b1111, 1'b1, 4'b0000};
        pu[8]  = '{32, 4'b1111, 1'b1, 4'b0000};
        pu[9]  = '{33, 4'b1111, 1'b1, 4'b0001};
        pu[10] = '{37, 4'b1111, 1'b1, 4'b0010};
        pu[11] = '{41, 4'b1111, 1'b1, 4'b0100};
        pu[12] = '{45, 4'b1111, 1'b1, 4'b1000};
        pu[13] = '{48, 4'b1111, 1'b1, 4'b0000};
        pu[14] = '{49, 4'b1111, 1'b1, 4'b0001};

        model_reset();
        repeat (3) step();

        // Power-up: resetn rises between edges t0 and t0+1.
        resetn = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 15; k++) begin
            while (cyc < t0 + pu[k].edge_n) step();
            chk("pu_rstn", 32'(ch_rstn), 32'(pu[k].rstn));
            chk("pu_ready", 32'(ready), 32'(pu[k].rdy));
            chk("pu_ce", 32'(ce), 32'(pu[k].cev));
        end

        // ch1 divisor 16 -> 3 mid-period: old pulse at +53, then every 3.
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd3;
        step();
        cfg_we = 1'b0;
        chk("div_ch1", 32'(ce[1]), 32'd0);
        while (cyc < t0 + 59) begin
            step();
            chk("div_ch1", 32'(ce[1]), 32'((cyc == t0 + 53) || (cyc == t0 + 56) || (cyc == t0 + 59)));
        end

        // ch2 divisor 0, then 1: constant ce from the next wrap (+73) on.
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd0;
        step();
        cfg_we = 1'b0;
        while (cyc < t0 + 72) step();
        chk("div0_pre", 32'(ce[2]), 32'd0);
        repeat (8) begin
            step();
            chk("div0_const", 32'(ce[2]), 32'd1);
        end
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd1;
        step();
        cfg_we = 1'b0;
        repeat (5) begin
            step();
            chk("div1_const", 32'(ce[2]), 32'd1);
        end

        // cfg_ch=3 is a real channel on dut, out of range on dut3.
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd2;
        step();
        cfg_we = 1'b0;

        // Soft reset in RUN, then again during HOLD.
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        chk("soft_rstn", 32'(ch_rstn), 32'd0);
        chk("soft_ready", 32'(ready), 32'd0);
        repeat (5) step();
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        ts2 = cyc;
        while (cyc < ts2 + 15) step();
        chk("hold_ext", 32'(ch_rstn[0]), 32'd0);
        step();
        chk("hold_ext_rel", 32'(ch_rstn[0]), 32'd1);
        while (cyc < ts2 + 22) step();
        chk("keep_div", 32'(ce[1]), 32'd1);
        step();
        chk("keep_div_gap", 32'(ce[1]), 32'd0);

        // resetn pulse during RELEASE: async clear, divisors back to default.
        assert_reset();
        step();
        resetn = 1'b1;
        t1 = cyc;
        while (cyc < t1 + 17) step();
        chk("rerst_hold", 32'(ch_rstn), 32'd0);
        step();
        chk("rerst_rel", 32'(ch_rstn), 32'd1);
        while (cyc < t1 + 24) step();
        chk("rerst_div1_gap", 32'(ce[1]), 32'd0);
        while (cyc < t1 + 33) step();
        chk("rerst_ce0", 32'(ce[0]), 32'd1);
        while (cyc < t1 + 37) step();
        chk("rerst_ce1", 32'(ce[1]), 32'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            cfg_we       = ($urandom_range(0, 7) == 0);
            cfg_ch       = 2'($urandom_range(0, 3));
            cfg_div      = 16'($urandom_range(0, 20));
            soft_rst_req = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 599) == 0) begin
                assert_reset();
                step();
                resetn = 1'b1;
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
